cpu_run_controller: RTL

Parametrised run controller and verdict monitor for `risc_v_cpu`. It generates the CPU reset, runs the CPU for a bounded cycle budget, watches the CPU's `check` word and latches a PASS / FAIL / TIMEOUT verdict. It wraps the CPU both in simulation benches and in on-board FPGA self-test, replacing fixed delay-based reset and finish timing with counted, configurable behaviour.

---
 rtl/cpu_run_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cpu_run_controller.sv
// Run controller: holds cpu_res for RESET_CYCLES, runs a bounded budget, latches PASS/FAIL/TIMEOUT.
// All outputs registered (one cycle after the deciding edge); start is ignored while busy, only RES aborts.
module cpu_run_controller #(
    parameter int unsigned       DATA_W        = 32,
    parameter int unsigned       CNT_W         = 32,
    parameter int unsigned       RESET_CYCLES  = 1000,
    parameter int unsigned       RUN_CYCLES    = 1000,
    parameter logic [DATA_W-1:0] PASS_VALUE    = DATA_W'(32'h0000_0001),
    parameter logic [DATA_W-1:0] FAIL_VALUE    = DATA_W'(32'hFFFF_FFFF),
    parameter int unsigned       STABLE_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              start,
    input  logic [DATA_W-1:0] check,
    output logic              cpu_res,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  run_cycles,
    output logic [DATA_W-1:0] last_check
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] RESET_LIM  = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] RUN_LIM    = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]   run_cycles_q, run_cycles_d;
    logic [DATA_W-1:0]  last_check_q, last_check_d;
    logic               cpu_res_q, cpu_res_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               timeout_q, timeout_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        run_cnt_d    = run_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        run_cycles_d = run_cycles_q;
        last_check_d = last_check_q;

        case (state_q)
            S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
                if (start) begin
                    state_d      = S_RESET;
                    rst_cnt_d    = '0;
                    run_cnt_d    = '0;
                    pass_cnt_d   = '0;
                    fail_cnt_d   = '0;
                    run_cycles_d = '0;
                end
            end
            S_RESET: begin
                rst_cnt_d = sat_inc(rst_cnt_q);
                if (rst_cnt_d >= RESET_LIM) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                run_cnt_d    = sat_inc(run_cnt_q);
                run_cycles_d = run_cnt_d;
                last_check_d = check;
                pass_cnt_d   = (check == PASS_VALUE) ? sat_inc(pass_cnt_q) : '0;
                fail_cnt_d   = (check == FAIL_VALUE) ? sat_inc(fail_cnt_q) : '0;
                // A verdict completing on the last budget cycle beats the timeout.
                if (pass_cnt_d >= STABLE_LIM) begin
                    state_d = S_PASS;
                end else if (fail_cnt_d >= STABLE_LIM) begin
                    state_d = S_FAIL;
                end else if (run_cnt_d >= RUN_LIM) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_res_d = (state_d != S_RUN);
        busy_d    = (state_d == S_RESET) || (state_d == S_RUN);
        done_d    = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
        pass_d    = (state_d == S_PASS);
        fail_d    = (state_d == S_FAIL);
        timeout_d = (state_d == S_TIMEOUT);
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            run_cnt_q    <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            run_cycles_q <= '0;
            last_check_q <= '0;
            cpu_res_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            run_cnt_q    <= run_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            run_cycles_q <= run_cycles_d;
            last_check_q <= last_check_d;
            cpu_res_q    <= cpu_res_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
        end
    end

    assign cpu_res    = cpu_res_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign timeout    = timeout_q;
    assign run_cycles = run_cycles_q;
    assign last_check = last_check_q;

endmodule
